// File: rtl/core_types_pkg.sv
// Shared fetch-predictor types and constants: return address stack geometry,
// reset fill value and the per-branch RAS checkpoint record.
package core_types_pkg;

    localparam int RAS_ENTRIES         = 8;
    localparam int RAS_INDEX_WIDTH     = $clog2(RAS_ENTRIES);
    localparam int RAS_TARGET_WIDTH    = 31;
    localparam int LOG_RAS_COUNT_WIDTH = $clog2(RAS_ENTRIES + 1);

    localparam logic [31:0] INIT_PC = 32'h8000_0000;

    // Targets are stored without PC[0], which is always zero for fetch addresses.
    localparam logic [RAS_TARGET_WIDTH-1:0] RAS_INIT_TARGET = INIT_PC[31:1];
    localparam logic [LOG_RAS_COUNT_WIDTH-1:0] RAS_FULL_COUNT =
        LOG_RAS_COUNT_WIDTH'(RAS_ENTRIES);

    typedef struct packed {
        logic [RAS_INDEX_WIDTH-1:0]     index;
        logic [LOG_RAS_COUNT_WIDTH-1:0] count;
        logic [RAS_TARGET_WIDTH-1:0]    top_target;
    } ras_checkpoint_t;

    function automatic logic [LOG_RAS_COUNT_WIDTH-1:0] clamp_ras_count(
        input logic [LOG_RAS_COUNT_WIDTH-1:0] count
    );
        return (count > RAS_FULL_COUNT) ? RAS_FULL_COUNT : count;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// 8-entry circular return address stack: push on calls, pop on returns,
// and restore pointer/occupancy/top entry from a branch checkpoint.
module ras_stack
    import core_types_pkg::*;
(
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           ras_push,
    input  logic [RAS_TARGET_WIDTH-1:0]    ras_push_target,
    input  logic                           ras_pop,
    output logic [RAS_TARGET_WIDTH-1:0]    ras_ret_target,
    output logic [RAS_INDEX_WIDTH-1:0]     ras_index,
    output logic [LOG_RAS_COUNT_WIDTH-1:0] ras_count,
    output logic                           ras_empty,
    input  logic                           update_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]     update_ras_index,
    input  logic [LOG_RAS_COUNT_WIDTH-1:0] update_ras_count,
    input  logic [RAS_TARGET_WIDTH-1:0]    update_ras_top_target
);

    logic [RAS_TARGET_WIDTH-1:0]    stack_q [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]     ptr_q, ptr_d;
    logic [LOG_RAS_COUNT_WIDTH-1:0] count_q, count_d;

    logic                           wr_en;
    logic [RAS_INDEX_WIDTH-1:0]     wr_idx;
    logic [RAS_TARGET_WIDTH-1:0]    wr_data;

    ras_checkpoint_t                upd;
    logic [LOG_RAS_COUNT_WIDTH-1:0] upd_count;

    assign upd       = '{index: update_ras_index, count: update_ras_count,
                         top_target: update_ras_top_target};
    assign upd_count = clamp_ras_count(upd.count);

    // Outputs come straight from flops, so a pop sees the top as it was before the edge.
    assign ras_ret_target = stack_q[ptr_q];
    assign ras_index      = ptr_q;
    assign ras_count      = count_q;
    assign ras_empty      = (count_q == '0);

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        wr_data = ras_push_target;

        if (update_valid) begin
            ptr_d   = upd.index;
            count_d = upd_count;
            wr_en   = (upd_count != '0);
            wr_idx  = upd.index;
            wr_data = upd.top_target;
        end else if (ras_push && ras_pop) begin
            // Coroutine-style jalr: replace the top in place.
            wr_en = 1'b1;
        end else if (ras_push) begin
            ptr_d   = ptr_q + RAS_INDEX_WIDTH'(1);
            wr_en   = 1'b1;
            wr_idx  = ptr_q + RAS_INDEX_WIDTH'(1);
            count_d = (count_q == RAS_FULL_COUNT) ? RAS_FULL_COUNT
                                                  : count_q + LOG_RAS_COUNT_WIDTH'(1);
        end else if (ras_pop && (count_q != '0)) begin
            ptr_d   = ptr_q - RAS_INDEX_WIDTH'(1);
            count_d = count_q - LOG_RAS_COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack_q[i] <= RAS_INIT_TARGET;
            end
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (wr_en) begin
                stack_q[wr_idx] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_ras_stack.sv
// Self-checking bench for ras_stack: directed scenarios plus randomized traffic
// compared against a behavioural stack model.
module tb_ras_stack;
    import core_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ras_push = 1'b0;
    logic [30:0] ras_push_target = '0;
    logic        ras_pop = 1'b0;
    logic [30:0] ras_ret_target;
    logic [2:0]  ras_index;
    logic [3:0]  ras_count;
    logic        ras_empty;
    logic        update_valid = 1'b0;
    logic [2:0]  update_ras_index = '0;
    logic [3:0]  update_ras_count = '0;
    logic [30:0] update_ras_top_target = '0;

    int checks   = 0;
    int failures = 0;

    localparam logic [38:0] RESET_OBS = {31'h4000_0000, 3'd0, 4'd0, 1'b1};

    ras_stack dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .ras_push              (ras_push),
        .ras_push_target       (ras_push_target),
        .ras_pop               (ras_pop),
        .ras_ret_target        (ras_ret_target),
        .ras_index             (ras_index),
        .ras_count             (ras_count),
        .ras_empty             (ras_empty),
        .update_valid          (update_valid),
        .update_ras_index      (update_ras_index),
        .update_ras_count      (update_ras_count),
        .update_ras_top_target (update_ras_top_target)
    );

    always #5 CLK = ~CLK;

    // Observation bundle {ret_target, index, count, empty}
    logic [38:0] dut_obs;
    assign dut_obs = {ras_ret_target, ras_index, ras_count, ras_empty};

    // ---------------- behavioural reference model ----------------
    logic [30:0] m_stack [8];
    int          m_ptr;
    int          m_count;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_stack[i] = 31'h4000_0000;
        m_ptr   = 0;
        m_count = 0;
    endfunction

    function automatic logic [38:0] model_obs();
        logic [2:0] p;
        logic [3:0] c;
        p = m_ptr[2:0];
        c = m_count[3:0];
        return {m_stack[m_ptr], p, c, (m_count == 0)};
    endfunction

    function automatic void model_apply();
        int uc;
        if (update_valid) begin
            uc      = int'(update_ras_count);
            m_ptr   = int'(update_ras_index);
            m_count = (uc > 8) ? 8 : uc;
            if (m_count != 0) m_stack[m_ptr] = update_ras_top_target;
        end else if (ras_push && ras_pop) begin
            m_stack[m_ptr] = ras_push_target;
        end else if (ras_push) begin
            m_ptr          = (m_ptr + 1) % 8;
            m_stack[m_ptr] = ras_push_target;
            m_count        = (m_count + 1 > 8) ? 8 : m_count + 1;
        end else if (ras_pop && m_count > 0) begin
            m_ptr   = (m_ptr + 7) % 8;
            m_count = m_count - 1;
        end
    endfunction

    // ---------------- driver tasks (called at negedge) ----------------
    task automatic set_in(input logic push, input logic [30:0] pt, input logic pop,
                          input logic upd = 1'b0, input logic [2:0] uidx = '0,
                          input logic [3:0] ucnt = '0, input logic [30:0] utop = '0);
        ras_push              = push;
        ras_push_target       = pt;
        ras_pop               = pop;
        update_valid          = upd;
        update_ras_index      = uidx;
        update_ras_count      = ucnt;
        update_ras_top_target = utop;
        #1;
    endtask

    task automatic idle_inputs();
        ras_push     = 1'b0;
        ras_pop      = 1'b0;
        update_valid = 1'b0;
    endtask

    task automatic clock_edge();
        @(posedge CLK);
        model_apply();
        @(negedge CLK);
        idle_inputs();
        #1;
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        idle_inputs();
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b0;
        #2 RST = 1'b1;
        model_reset();
        @(negedge CLK);
        #1;
        checks++;
        if (dut_obs !== RESET_OBS) begin
            failures++;
            $display("FAIL reset_values: got %h expected %h", dut_obs, RESET_OBS);
        end
        RST = 1'b0;
        set_in(1'b0, '0, 1'b1);
        checks++;
        if (dut_obs !== RESET_OBS) begin
            failures++;
            $display("FAIL pop_empty_same_cycle: got %h expected %h", dut_obs, RESET_OBS);
        end
        clock_edge();
        checks++;
        if (dut_obs !== RESET_OBS) begin
            failures++;
            $display("FAIL pop_empty_next: got %h expected %h", dut_obs, RESET_OBS);
        end
    endtask

    task automatic test_push_pop();
        reset_dut();
        set_in(1'b1, 31'h1000, 1'b0); clock_edge();
        set_in(1'b1, 31'h2000, 1'b0); clock_edge();
        checks++;
        if (dut_obs !== {31'h2000, 3'd2, 4'd2, 1'b0}) begin
            failures++;
            $display("FAIL push_two: got %h expected %h", dut_obs, {31'h2000, 3'd2, 4'd2, 1'b0});
        end
        set_in(1'b0, '0, 1'b1);
        checks++;
        if (ras_ret_target !== 31'h2000) begin
            failures++;
            $display("FAIL pop_same_cycle_target: got %h expected %h", ras_ret_target, 31'h2000);
        end
        clock_edge();
        checks++;
        if (dut_obs !== {31'h1000, 3'd1, 4'd1, 1'b0}) begin
            failures++;
            $display("FAIL pop_next: got %h expected %h", dut_obs, {31'h1000, 3'd1, 4'd1, 1'b0});
        end
    endtask

    task automatic test_wrap_saturate();
        logic [30:0] exp_t;
        reset_dut();
        for (int v = 1; v <= 9; v++) begin
            set_in(1'b1, 31'(v), 1'b0);
            clock_edge();
        end
        checks++;
        if (dut_obs !== {31'd9, 3'd1, 4'd8, 1'b0}) begin
            failures++;
            $display("FAIL nine_pushes: got %h expected %h", dut_obs, {31'd9, 3'd1, 4'd8, 1'b0});
        end
        for (int i = 0; i < 8; i++) begin
            exp_t = 31'(9 - i);
            set_in(1'b0, '0, 1'b1);
            checks++;
            if (ras_ret_target !== exp_t) begin
                failures++;
                $display("FAIL pop_order_%0d: got %h expected %h", i, ras_ret_target, exp_t);
            end
            clock_edge();
        end
        // Value 1 was overwritten by 9, so the stale top at ptr 1 is 9.
        checks++;
        if (dut_obs !== {31'd9, 3'd1, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL drained: got %h expected %h", dut_obs, {31'd9, 3'd1, 4'd0, 1'b1});
        end
    endtask

    task automatic test_push_and_pop();
        reset_dut();
        set_in(1'b1, 31'd5, 1'b0); clock_edge();
        set_in(1'b1, 31'h3000, 1'b1);
        checks++;
        if (ras_ret_target !== 31'd5) begin
            failures++;
            $display("FAIL coroutine_same_cycle: got %h expected %h", ras_ret_target, 31'd5);
        end
        clock_edge();
        checks++;
        if (dut_obs !== {31'h3000, 3'd1, 4'd1, 1'b0}) begin
            failures++;
            $display("FAIL coroutine_next: got %h expected %h", dut_obs, {31'h3000, 3'd1, 4'd1, 1'b0});
        end
    endtask

    task automatic test_checkpoint();
        ras_checkpoint_t cp;
        reset_dut();
        cp = '{index: 3'd3, count: 4'd3, top_target: 31'h0ABC};
        set_in(1'b1, 31'h0111, 1'b0); clock_edge();
        set_in(1'b1, 31'h0222, 1'b0); clock_edge();
        set_in(1'b1, 31'h0ABC, 1'b0); clock_edge();
        checks++;
        if (dut_obs !== {cp.top_target, cp.index, cp.count, 1'b0}) begin
            failures++;
            $display("FAIL checkpoint_state: got %h expected %h", dut_obs, {cp.top_target, cp.index, cp.count, 1'b0});
        end
        set_in(1'b0, '0, 1'b1); clock_edge();
        set_in(1'b0, '0, 1'b1); clock_edge();
        set_in(1'b1, 31'h0777, 1'b0); clock_edge();
        set_in(1'b1, 31'h5555, 1'b0, 1'b1, cp.index, cp.count, cp.top_target);
        clock_edge();
        checks++;
        if (dut_obs !== {31'h0ABC, 3'd3, 4'd3, 1'b0}) begin
            failures++;
            $display("FAIL checkpoint_restore: got %h expected %h", dut_obs, {31'h0ABC, 3'd3, 4'd3, 1'b0});
        end
    endtask

    task automatic test_update_clamp();
        reset_dut();
        set_in(1'b0, '0, 1'b0, 1'b1, 3'd5, 4'd12, 31'h1234);
        clock_edge();
        checks++;
        if (dut_obs !== {31'h1234, 3'd5, 4'd8, 1'b0}) begin
            failures++;
            $display("FAIL update_clamp: got %h expected %h", dut_obs, {31'h1234, 3'd5, 4'd8, 1'b0});
        end
        set_in(1'b0, '0, 1'b0, 1'b1, 3'd6, 4'd0, 31'h9999);
        clock_edge();
        checks++;
        if (dut_obs !== {31'h4000_0000, 3'd6, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL update_zero_nowrite: got %h expected %h", dut_obs, {31'h4000_0000, 3'd6, 4'd0, 1'b1});
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        set_in(1'b1, 31'h0AAA, 1'b0); clock_edge();
        set_in(1'b1, 31'h0BBB, 1'b1);
        #2 RST = 1'b1;
        #1;
        checks++;
        if (dut_obs !== RESET_OBS) begin
            failures++;
            $display("FAIL async_reset_immediate: got %h expected %h", dut_obs, RESET_OBS);
        end
        @(posedge CLK);
        @(negedge CLK);
        idle_inputs();
        RST = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_obs !== RESET_OBS) begin
            failures++;
            $display("FAIL async_reset_discard: got %h expected %h", dut_obs, RESET_OBS);
        end
    endtask

    task automatic test_random();
        logic [38:0] exp_o;
        reset_dut();
        for (int n = 0; n < 300; n++) begin
            set_in(1'($urandom_range(0, 1)), 31'($urandom), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                   4'($urandom_range(0, 15)), 31'($urandom));
            exp_o = model_obs();
            checks++;
            if (dut_obs !== exp_o) begin
                failures++;
                $display("FAIL random_pre_%0d: got %h expected %h", n, dut_obs, exp_o);
            end
            clock_edge();
            exp_o = model_obs();
            checks++;
            if (dut_obs !== exp_o) begin
                failures++;
                $display("FAIL random_post_%0d: got %h expected %h", n, dut_obs, exp_o);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_push_pop();
        test_wrap_saturate();
        test_push_and_pop();
        test_checkpoint();
        test_update_clamp();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
